// File: rtl/div3_seq.sv
// Sequential divide-by-3: MSB-first restoring recurrence, one quotient bit per clock.
// Optional DIV3_SELFCHECK_EN adds chk_err, a reconstruction check of the held result.
module div3_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] digit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [1:0]       remainder,
   output logic             OUT
`ifdef DIV3_SELFCHECK_EN
   ,
   output logic             chk_err
`endif
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_ready is high only in IDLE, out_valid only in DONE; once raised,
   // out_valid and the result stay put until out_ready is seen.

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] q_run;
   logic [1:0]       rem_run;
   logic [CW-1:0]    cnt;

   logic [2:0]       t;
   logic [2:0]       t_diff;
   logic             qbit;
   logic [1:0]       rem_next;
   logic [WIDTH-1:0] q_next;

   // Running remainder stays in 0..2, so t = 2*rem + bit never exceeds 5.
   always_comb begin
      t        = {rem_run, shift_reg[WIDTH-1]};
      t_diff   = t - 3'd3;
      qbit     = (t >= 3'd3);
      rem_next = qbit ? t_diff[1:0] : t[1:0];
      q_next   = {q_run[WIDTH-2:0], qbit};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (cnt == '0) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

`ifdef DIV3_SELFCHECK_EN
   logic [WIDTH-1:0] op_copy;
   logic [WIDTH+1:0] recon;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              op_copy <= '0;
      else if (state == IDLE && in_valid)   op_copy <= digit;
   end

   always_comb begin
      recon   = ({2'b00, quotient} * (WIDTH+2)'(3)) + {{WIDTH{1'b0}}, remainder};
      chk_err = out_valid && (recon != {2'b00, op_copy});
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         q_run     <= '0;
         rem_run   <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         OUT       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_reg <= digit;
                  q_run     <= '0;
                  rem_run   <= '0;
                  cnt       <= LAST;
               end
            end
            CALC: begin
               shift_reg <= shift_reg << 1;
               q_run     <= q_next;
               rem_run   <= rem_next;
               cnt       <= cnt - 1'b1;
               // Last bit: publish the completed result straight from the recurrence.
               if (cnt == '0) begin
                  quotient  <= q_next;
                  remainder <= rem_next;
                  OUT       <= (rem_next == 2'd0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div3_seq.sv
// Self-checking bench for div3_seq (WIDTH=8): directed scenarios plus random and
// exhaustive operands compared against plain integer division by 3.
module tb_div3_seq;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] digit = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] quotient;
   logic [1:0]       remainder;
   logic             OUT;
`ifdef DIV3_SELFCHECK_EN
   logic             chk_err;
`endif

   int total = 0;
   int bad   = 0;

   div3_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .digit     (digit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .OUT       (OUT)
`ifdef DIV3_SELFCHECK_EN
      ,
      .chk_err   (chk_err)
`endif
   );

   always #5 clk = ~clk;

   // Drivers: all are entered and left 1ns after a rising edge.
   task automatic send(input logic [WIDTH-1:0] d);
      in_valid = 1'b1;
      digit    = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if ({quotient, remainder, OUT} !== '0) begin bad++; $display("FAIL reset_outputs got q=%0d r=%0d out=%b want 0", quotient, remainder, OUT); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_max();
      int cyc;
      send(8'hFF);
      wait_done(cyc);
      total++; if (cyc !== WIDTH) begin bad++; $display("FAIL max_latency got=%0d want=%0d", cyc, WIDTH); end
      total++; if (quotient !== 8'd85 || remainder !== 2'd0 || OUT !== 1'b1) begin bad++; $display("FAIL max_result got q=%0d r=%0d out=%b want q=85 r=0 out=1", quotient, remainder, OUT); end
      consume();
   endtask

   task automatic test_sequence();
      logic [WIDTH-1:0] ops [5] = '{8'h52, 8'h40, 8'h1F, 8'h00, 8'h8C};
      int cyc;
      for (int i = 0; i < 5; i++) begin
         send(ops[i]);
         wait_done(cyc);
         total++; if (cyc !== WIDTH) begin bad++; $display("FAIL seq_latency[%0d] got=%0d want=%0d", i, cyc, WIDTH); end
         total++; if (quotient !== WIDTH'(int'(ops[i]) / 3) || remainder !== 2'(int'(ops[i]) % 3) || OUT !== (int'(ops[i]) % 3 == 0)) begin
            bad++; $display("FAIL seq_result[%0d] d=%0d got q=%0d r=%0d out=%b want q=%0d r=%0d", i, ops[i], quotient, remainder, OUT, int'(ops[i]) / 3, int'(ops[i]) % 3);
         end
         consume();
         total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL seq_release[%0d] got in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid); end
      end
   endtask

   task automatic test_stall();
      int cyc;
      send(8'h36);
      wait_done(cyc);
      total++; if (cyc !== WIDTH) begin bad++; $display("FAIL stall_latency got=%0d want=%0d", cyc, WIDTH); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold_hs[%0d] got out_valid=%b in_ready=%b want 1 0", i, out_valid, in_ready); end
         total++; if (quotient !== 8'd18 || remainder !== 2'd0 || OUT !== 1'b1) begin bad++; $display("FAIL stall_hold_data[%0d] got q=%0d r=%0d out=%b want 18 0 1", i, quotient, remainder, OUT); end
      end
      consume();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_ignore_busy();
      int cyc;
      send(8'h0C);
      in_valid = 1'b1;
      digit    = 8'hFF;
      wait_done(cyc);
      total++; if (cyc !== WIDTH) begin bad++; $display("FAIL busy_latency got=%0d want=%0d", cyc, WIDTH); end
      total++; if (quotient !== 8'd4 || remainder !== 2'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL busy_result got q=%0d r=%0d in_ready=%b want 4 0 0", quotient, remainder, in_ready); end
      consume();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL busy_idle got in_ready=%b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_accept got in_ready=%b want 0", in_ready); end
      wait_done(cyc);
      total++; if (cyc !== WIDTH || quotient !== 8'd85 || remainder !== 2'd0) begin bad++; $display("FAIL busy_second got cyc=%0d q=%0d r=%0d want %0d 85 0", cyc, quotient, remainder, WIDTH); end
      consume();
   endtask

   task automatic test_abort();
      int cyc;
      send(8'hFC);
      repeat (2) begin @(posedge clk); #1; end
      #2;
      rst = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL abort_hs got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
      total++; if ({quotient, remainder, OUT} !== '0) begin bad++; $display("FAIL abort_outputs got q=%0d r=%0d out=%b want 0", quotient, remainder, OUT); end
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      send(8'h03);
      wait_done(cyc);
      total++; if (cyc !== WIDTH || quotient !== 8'd1 || remainder !== 2'd0 || OUT !== 1'b1) begin bad++; $display("FAIL abort_recover got cyc=%0d q=%0d r=%0d out=%b want %0d 1 0 1", cyc, quotient, remainder, OUT, WIDTH); end
      consume();
   endtask

   task automatic test_random();
      int cyc, d, stall;
      for (int i = 0; i < 40; i++) begin
         d = int'($urandom_range(255, 0));
         stall = int'($urandom_range(3, 0));
         send(WIDTH'(d));
         wait_done(cyc);
         repeat (stall) begin @(posedge clk); #1; end
         total++; if (cyc !== WIDTH || out_valid !== 1'b1 || quotient !== WIDTH'(d / 3) || remainder !== 2'(d % 3) || OUT !== (d % 3 == 0)) begin
            bad++; $display("FAIL random[%0d] d=%0d got cyc=%0d q=%0d r=%0d out=%b want q=%0d r=%0d", i, d, cyc, quotient, remainder, OUT, d / 3, d % 3);
         end
         consume();
      end
   endtask

   task automatic test_exhaustive();
      int cyc;
      for (int d = 0; d < 256; d++) begin
         send(WIDTH'(d));
         wait_done(cyc);
         total++; if (cyc !== WIDTH || quotient !== WIDTH'(d / 3) || remainder !== 2'(d % 3) || OUT !== (d % 3 == 0)) begin
            bad++; $display("FAIL exhaustive d=%0d got cyc=%0d q=%0d r=%0d out=%b want q=%0d r=%0d", d, cyc, quotient, remainder, OUT, d / 3, d % 3);
         end
`ifdef DIV3_SELFCHECK_EN
         total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_err d=%0d got=%b want=0", d, chk_err); end
`endif
         consume();
      end
   endtask

   initial begin
      test_reset();
      test_max();
      test_sequence();
      test_stall();
      test_ignore_busy();
      test_abort();
      test_random();
      test_exhaustive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div3_seq.md
Name: div3_seq

Overview:
- Sequential divide-by-3 unit; the inverse companion to the combinational divisibility checker.
- Takes an unsigned operand on a valid/ready handshake.
- Computes quotient and remainder MSB-first, one bit per clock, using a 3-state remainder recurrence.
- Presents quotient, remainder and a divisible flag on an output valid/ready handshake.
- Used wherever a result must be scaled by 1/3, not just tested for divisibility.

Parameters:
- WIDTH, 8, operand and quotient width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand on digit is valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- digit  input  WIDTH  unsigned dividend.
- out_valid  output  1  quotient/remainder/OUT valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- quotient  output  WIDTH  floor(digit/3).
- remainder  output  2  digit mod 3; values 0..2 only.
- OUT  output  1  1 when remainder==0, i.e. digit divisible by 3.

Behaviour:
- Reset: clk and rst as named above; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, OUT=0, internal shift register=0, bit counter=0.
- rst asserted in any state aborts the operation immediately. The in-flight operand is discarded with no partial result.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch digit into shift register, clear running remainder, load counter=WIDTH-1, go to CALC.
- CALC:
  - in_ready=0; in_valid is ignored.
  - Each edge: t = {rem[1:0], shift_msb} (3 bits, 0..5); qbit = (t>=3); rem_next = t - (qbit ? 3 : 0).
  - Shift qbit into the quotient LSB; shift the operand register left by 1.
  - On the edge processing counter==0: load quotient, remainder and OUT output registers, go to DONE.
- Latency:
  - Acceptance at edge k → out_valid high after edge k+WIDTH, i.e. exactly WIDTH cycles.
  - No early termination.
- DONE:
  - out_valid=1.
  - quotient, remainder and OUT are held stable until out_valid && out_ready on an edge, then go to IDLE.
- Back-to-back operation:
  - No same-cycle accept on the handshake cycle. in_ready rises the cycle after the result is consumed.
  - Throughput is one operand per WIDTH+2 cycles minimum.
- Output hold:
  - Outputs keep their last values in IDLE/CALC.
  - They are only meaningful while out_valid=1. OUT is defined only while out_valid=1.
- Arithmetic invariant at DONE: quotient*3 + remainder == latched digit; remainder < 3.
- Boundary values:
  - digit=0 → q=0, r=0, OUT=1.
  - digit=2^WIDTH-1 → q=(2^WIDTH-1)/3 exactly when WIDTH is even.
- Handshake signals: in_valid/in_ready and out_valid/out_ready follow standard valid/ready rules. out_valid never drops without out_ready.

Optional Feature:
- Macro: DIV3_SELFCHECK_EN.
- When defined:
  - Adds output port chk_err (1 bit, reset 0).
  - In DONE, the block computes quotient*3 + remainder combinationally and compares it with a retained copy of the accepted operand.
  - chk_err=1 while out_valid=1 and the compare mismatches; 0 otherwise.
  - chk_err is cleared on leaving DONE.
- When undefined: no chk_err port, no operand copy register, no multiplier/compare logic; all other behaviour is identical.

Test Plan:
- Reset, then digit=8'hFF with in_valid=1 for one edge → out_valid after exactly 8 cycles; quotient=85, remainder=0, OUT=1.
- Sequence 8'h52, 8'h40, 8'h1F, 8'h00, 8'h8C, each with out_ready=1 → (27,1,0), (21,1,0), (10,1,0), (0,0,1), (46,2,0).
- digit=8'h36, hold out_ready=0 for 5 cycles → out_valid stays 1; quotient=18, remainder=0, OUT=1 stable; in_ready=0. out_ready=1 → IDLE, in_ready=1 on the next cycle.
- Accept 8'h0C, then drive in_valid=1 with 8'hFF during CALC → ignored; result quotient=4, remainder=0; 8'hFF is accepted only after return to IDLE.
- Accept 8'hFC, assert rst asynchronously mid-CALC (cycle 3) → outputs go to reset values immediately, in_ready=1. A new 8'h03 → q=1, r=0, OUT=1.
- With DIV3_SELFCHECK_EN, run all 256 operands → chk_err stays 0 and the invariant holds for every result. Without the macro, the bench compiles without chk_err.
